// File: rtl/regfile_write_buffer_if.sv
// Bus between a writeback producer and regfile_write_buffer: push handshake,
// drain control, regfile write port, forwarding queries and occupancy.
interface regfile_write_buffer_if #(
  parameter int DEPTH  = 4,
  parameter int ADR_W  = 6,
  parameter int DATA_W = 64
);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic              inValid;
  logic              inReady;
  logic [ADR_W-1:0]  inAdr;
  logic [DATA_W-1:0] inData;
  logic              drainEn;
  logic [ADR_W-1:0]  writeAdr;
  logic [DATA_W-1:0] writeData;
  logic              writeEnable;
  logic [ADR_W-1:0]  lookupAdr1;
  logic [ADR_W-1:0]  lookupAdr2;
  logic              fwdHit1;
  logic [DATA_W-1:0] fwdData1;
  logic              fwdHit2;
  logic [DATA_W-1:0] fwdData2;
  logic [CNT_W-1:0]  count;

  modport master (
    output inValid, inAdr, inData, drainEn, lookupAdr1, lookupAdr2,
    input  inReady, writeAdr, writeData, writeEnable,
           fwdHit1, fwdData1, fwdHit2, fwdData2, count
  );

  modport slave (
    input  inValid, inAdr, inData, drainEn, lookupAdr1, lookupAdr2,
    output inReady, writeAdr, writeData, writeEnable,
           fwdHit1, fwdData1, fwdHit2, fwdData2, count
  );
endinterface

// File: rtl/regfile_write_buffer.sv
// In-order writeback FIFO feeding the register file write port through a
// registered output stage, with two youngest-match forwarding lookups.
module regfile_write_buffer #(
  parameter int DEPTH  = 4,
  parameter int ADR_W  = 6,
  parameter int DATA_W = 64
) (
  input logic                   clk,
  input logic                   resetN,
  regfile_write_buffer_if.slave bus
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [ADR_W-1:0]  adrMem  [DEPTH];
  logic [DATA_W-1:0] dataMem [DEPTH];
  logic [PTR_W-1:0]  rdPtr;
  logic [PTR_W-1:0]  wrPtr;
  logic [CNT_W-1:0]  countQ;
  logic [ADR_W-1:0]  writeAdrQ;
  logic [DATA_W-1:0] writeDataQ;
  logic              writeEnableQ;

  logic full;
  logic push;
  logic pop;

  // Ready depends on occupancy alone, so a full buffer refuses a push even
  // when a pop happens on the same edge.
  assign full = (countQ == CNT_W'(DEPTH));
  assign push = bus.inValid && !full;
  assign pop  = bus.drainEn && (countQ != '0);

  // NOTE: storage is left unreset on purpose; validity comes from count and
  // the pointers, so stale contents are never observed.
  always_ff @(posedge clk) begin
    if (push) begin
      adrMem[wrPtr]  <= bus.inAdr;
      dataMem[wrPtr] <= bus.inData;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // right-hand side sees pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!resetN) begin
      rdPtr        <= '0;
      wrPtr        <= '0;
      countQ       <= '0;
      writeEnableQ <= 1'b0;
      writeAdrQ    <= '0;
      writeDataQ   <= '0;
    end else begin
      if (push) wrPtr <= wrPtr + 1'b1;
      if (pop) begin
        rdPtr      <= rdPtr + 1'b1;
        writeAdrQ  <= adrMem[rdPtr];
        writeDataQ <= dataMem[rdPtr];
      end
      writeEnableQ <= pop;
      if (push && !pop)      countQ <= countQ + 1'b1;
      else if (pop && !push) countQ <= countQ - 1'b1;
    end
  end

  // Scan oldest to youngest so the newest match overwrites older ones; the
  // output stage is the oldest pending value of all.
  function automatic logic [DATA_W:0] lookup(input logic [ADR_W-1:0] adr);
    logic [DATA_W:0]  res;
    logic [PTR_W-1:0] idx;
    res = '0;
    if (writeEnableQ && (writeAdrQ == adr)) res = {1'b1, writeDataQ};
    for (int k = 0; k < DEPTH; k++) begin
      idx = rdPtr + PTR_W'(k);
      if ((CNT_W'(k) < countQ) && (adrMem[idx] == adr)) res = {1'b1, dataMem[idx]};
    end
    return res;
  endfunction

  // NOTE: every always_comb output gets a default before any conditional
  // update, which keeps the block free of inferred latches.
  always_comb begin
    {bus.fwdHit1, bus.fwdData1} = '0;
    {bus.fwdHit2, bus.fwdData2} = '0;
    {bus.fwdHit1, bus.fwdData1} = lookup(bus.lookupAdr1);
    {bus.fwdHit2, bus.fwdData2} = lookup(bus.lookupAdr2);
  end

  assign bus.inReady     = !full;
  assign bus.count       = countQ;
  assign bus.writeAdr    = writeAdrQ;
  assign bus.writeData   = writeDataQ;
  assign bus.writeEnable = writeEnableQ;
endmodule
